// File: rtl/lfsr_gen_pkg.sv
// ============================================================================
// lfsr_pkg : mode encodings, maximal-length tap tables, golden step function
// Revision : 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    // Fibonacci masks (bit k set = state bit k feeds the XOR) for widths 2..16.
    function automatic logic [31:0] fib_taps(input int w);
        case (w)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Same polynomial in Galois form is the Fibonacci mask bit-reversed within w bits.
    function automatic logic [31:0] gal_taps(input int w);
        logic [31:0] f;
        logic [31:0] r;
        f = fib_taps(w);
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r = r | (((f >> i) & 32'h1) << (w - 1 - i));
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int          width,
                                              input int          mode);
        logic [31:0] mask;
        logic        msb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        msb  = ((state >> (width - 1)) & 32'h1) != 32'h0;
        if (mode == MODE_GAL) begin
            return ((state << 1) ^ (msb ? taps : 32'h0)) & mask;
        end
        return ((state << 1) | {31'h0, ^(state & taps & mask)}) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_gen_if.sv
// ============================================================================
// lfsr_gen_if : control/observation bundle of the LFSR generator
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface lfsr_gen_if #(
    parameter int WIDTH = 3
);
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             enable;
    logic [WIDTH-1:0] Qs;
    logic             serial_out;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] period_len;
    logic             period_done;
    logic             lockup;

    modport master (
        output load, seed_in, enable,
        input  Qs, serial_out, count, period_len, period_done, lockup
    );

    modport slave (
        input  load, seed_in, enable,
        output Qs, serial_out, count, period_len, period_done, lockup
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_gen_next.sv
// ============================================================================
// lfsr_next : combinational Fibonacci/Galois next-state logic
// Revision  : 1.0
// ============================================================================
`default_nettype none

module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110,
    parameter int               MODE  = MODE_FIB
) (
    input  wire logic [WIDTH-1:0] state_i,
    output logic      [WIDTH-1:0] next_o
);

    generate
        if (MODE == MODE_GAL) begin : g_galois
            assign next_o = {state_i[WIDTH-2:0], 1'b0} ^ (state_i[WIDTH-1] ? TAPS : '0);
        end else begin : g_fibonacci
            assign next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
// lfsr_gen : parametrised LFSR with seed load, lock-up recovery, period meter
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] SEED  = 3'b001
) (
    input wire logic  clk,
    input wire logic  reset,
    lfsr_gen_if.slave bus
);

    logic [WIDTH-1:0] qs_q,    qs_d;
    logic [WIDTH-1:0] seed_q,  seed_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] plen_q,  plen_d;
    logic             done_q,  done_d;
    logic             lock_q,  lock_d;
    logic [WIDTH-1:0] step_w;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .state_i (qs_q),
        .next_o  (step_w)
    );

    always_comb begin
        qs_d    = qs_q;
        seed_d  = seed_q;
        count_d = count_q;
        plen_d  = plen_q;
        done_d  = 1'b0;
        lock_d  = 1'b0;
        if (bus.load) begin
            qs_d    = bus.seed_in;
            seed_d  = bus.seed_in;
            count_d = '0;
        end else if (bus.enable) begin
            if (qs_q == '0) begin
                // All-zero is a fixed point of the XOR feedback; restart from SEED.
                qs_d    = SEED;
                seed_d  = SEED;
                count_d = '0;
                lock_d  = 1'b1;
            end else begin
                qs_d = step_w;
                if (step_w == seed_q) begin
                    count_d = '0;
                    plen_d  = count_q + WIDTH'(1);
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qs_q    <= SEED;
            seed_q  <= SEED;
            count_q <= '0;
            plen_q  <= '0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            qs_q    <= qs_d;
            seed_q  <= seed_d;
            count_q <= count_d;
            plen_q  <= plen_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
        end
    end

    assign bus.Qs          = qs_q;
    assign bus.serial_out  = qs_q[WIDTH-1];
    assign bus.count       = count_q;
    assign bus.period_len  = plen_q;
    assign bus.period_done = done_q;
    assign bus.lockup      = lock_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ============================================================================
// tb_lfsr_gen : directed scenarios on 3-bit Fibonacci/Galois plus randomized 5-bit run
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(3)) bf ();
    lfsr_gen_if #(.WIDTH(3)) bg ();
    lfsr_gen_if #(.WIDTH(5)) br ();

    lfsr_gen #(.WIDTH(3), .TAPS(3'b110), .MODE(MODE_FIB), .SEED(3'b001))
        dut_f (.clk(clk), .reset(reset), .bus(bf));
    lfsr_gen #(.WIDTH(3), .TAPS(3'b011), .MODE(MODE_GAL), .SEED(3'b001))
        dut_g (.clk(clk), .reset(reset), .bus(bg));
    lfsr_gen #(.WIDTH(5), .TAPS(5'b00101), .MODE(MODE_GAL), .SEED(5'b00001))
        dut_r (.clk(clk), .reset(reset), .bus(br));

    // Expected orbits written out by hand from the polynomials.
    logic [2:0] fib_seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
    logic [2:0] gal_seq [7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned model_next(int unsigned q, int unsigned taps, int w, bit gal);
        int unsigned mask;
        mask = (32'd1 << w) - 32'd1;
        if (gal) return ((q << 1) ^ ((((q >> (w - 1)) & 1) != 0) ? taps : 0)) & mask;
        return ((q << 1) | ($countones(q & taps) % 2)) & mask;
    endfunction

    task automatic test_reset();
        bf.load = 0; bf.enable = 0; bf.seed_in = '0;
        bg.load = 0; bg.enable = 0; bg.seed_in = '0;
        br.load = 0; br.enable = 0; br.seed_in = '0;
        #1 reset = 1'b0;
        #11;
        n_checks++;
        if ({bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup, bf.serial_out} !== {3'b001, 3'd0, 3'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_fib got Qs=%b cnt=%0d plen=%0d done=%b lock=%b expected 001 0 0 0 0",
                     bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup);
        end
        n_checks++;
        if ({bg.Qs, bg.count, bg.period_len, bg.period_done, bg.lockup} !== {3'b001, 3'd0, 3'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_gal got Qs=%b cnt=%0d plen=%0d done=%b lock=%b expected 001 0 0 0 0",
                     bg.Qs, bg.count, bg.period_len, bg.period_done, bg.lockup);
        end
        n_checks++;
        if ({br.Qs, br.count, br.period_len, br.period_done, br.lockup} !== {5'd1, 5'd0, 5'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_w5 got Qs=%h cnt=%0d plen=%0d expected 01 0 0", br.Qs, br.count, br.period_len);
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_fib_sequence();
        bf.enable = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if ({bf.Qs, bf.serial_out, bf.count, bf.period_len, bf.period_done, bf.lockup} !==
                {fib_seq[i % 7], fib_seq[i % 7][2], 3'(i % 7), (i == 7) ? 3'd7 : 3'd0, i == 7, 1'b0}) begin
                n_fail++;
                $display("FAIL fib_step%0d got Qs=%b ser=%b cnt=%0d plen=%0d done=%b lock=%b expected Qs=%b cnt=%0d",
                         i, bf.Qs, bf.serial_out, bf.count, bf.period_len, bf.period_done, bf.lockup,
                         fib_seq[i % 7], i % 7);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_checks++;
            if ({bf.Qs, bf.count} !== {fib_seq[i], 3'(i)}) begin
                n_fail++;
                $display("FAIL hold_pre%0d got Qs=%b cnt=%0d expected %b %0d", i, bf.Qs, bf.count, fib_seq[i], i);
            end
        end
        bf.enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup} !== {3'b101, 3'd2, 3'd7, 2'b00}) begin
                n_fail++;
                $display("FAIL hold%0d got Qs=%b cnt=%0d plen=%0d done=%b lock=%b expected 101 2 7 0 0",
                         i, bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup);
            end
        end
        bf.enable = 1;
        tick();
        n_checks++;
        if ({bf.Qs, bf.count} !== {3'b011, 3'd3}) begin
            n_fail++;
            $display("FAIL hold_resume got Qs=%b cnt=%0d expected 011 3", bf.Qs, bf.count);
        end
    endtask

    task automatic test_load();
        bf.load = 1; bf.seed_in = 3'b110;
        tick();
        bf.load = 0;
        n_checks++;
        if ({bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup} !== {3'b110, 3'd0, 3'd7, 2'b00}) begin
            n_fail++;
            $display("FAIL load got Qs=%b cnt=%0d plen=%0d done=%b expected 110 0 7 0",
                     bf.Qs, bf.count, bf.period_len, bf.period_done);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if ({bf.Qs, bf.count, bf.period_len, bf.period_done} !== {fib_seq[(5 + k) % 7], 3'(k % 7), 3'd7, k == 7}) begin
                n_fail++;
                $display("FAIL load_step%0d got Qs=%b cnt=%0d plen=%0d done=%b expected %b %0d 7 %0d",
                         k, bf.Qs, bf.count, bf.period_len, bf.period_done, fib_seq[(5 + k) % 7], k % 7, k == 7);
            end
        end
    endtask

    task automatic test_lockup();
        bf.enable = 0; bf.load = 1; bf.seed_in = 3'b000;
        tick();
        bf.load = 0;
        n_checks++;
        if ({bf.Qs, bf.count, bf.lockup} !== {3'b000, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_load got Qs=%b cnt=%0d lock=%b expected 000 0 0", bf.Qs, bf.count, bf.lockup);
        end
        bf.enable = 1;
        tick();
        n_checks++;
        if ({bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup} !== {3'b001, 3'd0, 3'd7, 2'b01}) begin
            n_fail++;
            $display("FAIL recovery got Qs=%b cnt=%0d plen=%0d done=%b lock=%b expected 001 0 7 0 1",
                     bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup);
        end
        tick();
        bf.enable = 0;
        n_checks++;
        if ({bf.Qs, bf.count, bf.period_done, bf.lockup} !== {3'b010, 3'd1, 2'b00}) begin
            n_fail++;
            $display("FAIL post_recovery got Qs=%b cnt=%0d done=%b lock=%b expected 010 1 0 0",
                     bf.Qs, bf.count, bf.period_done, bf.lockup);
        end
    endtask

    task automatic test_galois();
        bg.enable = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({bg.Qs, bg.count, bg.period_len, bg.period_done, bg.lockup} !==
                {gal_seq[i % 7], 3'(i % 7), (i >= 7) ? 3'd7 : 3'd0, i == 7, 1'b0}) begin
                n_fail++;
                $display("FAIL gal_step%0d got Qs=%b cnt=%0d plen=%0d done=%b expected Qs=%b cnt=%0d",
                         i, bg.Qs, bg.count, bg.period_len, bg.period_done, gal_seq[i % 7], i % 7);
            end
        end
        bg.enable = 0;
    endtask

    task automatic test_async_reset();
        bf.enable = 1;
        tick(); tick(); tick();
        n_checks++;
        if (bf.Qs !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_async got Qs=%b expected 111", bf.Qs);
        end
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({bf.Qs, bf.count, bf.period_len, bf.period_done, bf.lockup} !== {3'b001, 3'd0, 3'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL async_reset got Qs=%b cnt=%0d plen=%0d done=%b expected 001 0 0 0",
                     bf.Qs, bf.count, bf.period_len, bf.period_done);
        end
        tick(); tick();
        n_checks++;
        if ({bf.Qs, bf.count} !== {3'b001, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_hold got Qs=%b cnt=%0d expected 001 0", bf.Qs, bf.count);
        end
        #3 reset = 1'b1;
        tick();
        bf.enable = 0;
        n_checks++;
        if ({bf.Qs, bf.count, bf.period_len} !== {3'b010, 3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL restart got Qs=%b cnt=%0d plen=%0d expected 010 1 0", bf.Qs, bf.count, bf.period_len);
        end
    endtask

    task automatic test_random();
        int unsigned mq = 1, ms = 1, mc = 0, mp = 0, n;
        bit md = 0, ml = 0, ld, en;
        int unsigned sd;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ld = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) < 85);
            sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
            br.load = ld; br.enable = en; br.seed_in = 5'(sd);
            if (ld) begin
                mq = sd; ms = sd; mc = 0; md = 0; ml = 0;
            end else if (en && mq == 0) begin
                mq = 1; ms = 1; mc = 0; md = 0; ml = 1;
            end else if (en) begin
                n  = model_next(mq, 32'h05, 5, 1'b1);
                mq = n; ml = 0;
                if (n == ms) begin mp = (mc + 1) % 32; mc = 0; md = 1; end
                else begin mc = (mc + 1) % 32; md = 0; end
            end else begin
                md = 0; ml = 0;
            end
            tick();
            n_checks++;
            if ({br.Qs, br.serial_out, br.count, br.period_len, br.period_done, br.lockup} !==
                {5'(mq), mq[4], 5'(mc), 5'(mp), md, ml}) begin
                n_fail++;
                $display("FAIL rand_cycle%0d got Qs=%h cnt=%0d plen=%0d done=%b lock=%b expected Qs=%h cnt=%0d plen=%0d done=%b lock=%b",
                         cyc, br.Qs, br.count, br.period_len, br.period_done, br.lockup, mq, mc, mp, md, ml);
            end
        end
        br.load = 0; br.enable = 0;
    endtask

    initial begin
        test_reset();
        test_fib_sequence();
        test_hold();
        test_load();
        test_lockup();
        test_galois();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
